// File: rtl/alu_pkg.sv
// Shared constants for ALU decode and the multiply/divide unit: ALUCtl codes, ALUOp classes,
// MDU funct codes and the MDU sequencer states.
package alu_pkg;

   localparam logic [4:0] CTL_AND = 5'b00000;
   localparam logic [4:0] CTL_OR  = 5'b00001;
   localparam logic [4:0] CTL_ADD = 5'b00010;
   localparam logic [4:0] CTL_SUB = 5'b00110;
   localparam logic [4:0] CTL_SLT = 5'b00111;
   localparam logic [4:0] CTL_NOR = 5'b01100;
   localparam logic [4:0] CTL_XOR = 5'b01101;
   localparam logic [4:0] CTL_SLL = 5'b10000;
   localparam logic [4:0] CTL_SRL = 5'b11000;
   localparam logic [4:0] CTL_SRA = 5'b11001;
   localparam logic [4:0] CTL_MUL = 5'b11010;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_RTYPE = 3'b010;
   localparam logic [2:0] OP_AND   = 3'b100;
   localparam logic [2:0] OP_SLT   = 3'b101;
   localparam logic [2:0] OP_MUL   = 3'b110;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {IDLE, RUN, FIN} md_state_t;

   function automatic logic is_muldiv(input logic [5:0] f);
      return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
   endfunction

   function automatic logic is_md_funct(input logic [5:0] f);
      return is_muldiv(f) || (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO);
   endfunction

endpackage

// File: rtl/alu_control_mdu_iter.sv
// Iterative MDU datapath: one shift-add or restoring-divide step per step cycle on magnitudes,
// sign-corrected result. MDU_EARLY_TERM_EN ends a multiply once the remaining multiplier bits are zero.
import alu_pkg::*;

module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             step,
   input  logic             div_op,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi_res,
   output logic [WIDTH-1:0] lo_res
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [CNT_W-1:0]   cnt;
   logic               div_q, neg_q, neg_r, divz_q;
   logic [WIDTH-1:0]   a_raw, mplr, rem, quot, dvsr;
   logic [2*WIDTH-1:0] prod, mcand, prod_s;
   logic               a_neg, b_neg, r_ge;
   logic [WIDTH-1:0]   a_mag, b_mag, q_s, r_s;
   logic [WIDTH:0]     r_sh;

   assign a_neg = sgn & a[WIDTH-1];
   assign b_neg = sgn & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;
   assign r_sh  = {rem, quot[WIDTH-1]};
   assign r_ge  = r_sh >= {1'b0, dvsr};

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;  div_q <= 1'b0;  neg_q <= 1'b0;  neg_r <= 1'b0;  divz_q <= 1'b0;
         a_raw <= '0;  mplr <= '0;  rem <= '0;  quot <= '0;  dvsr <= '0;
         prod <= '0;  mcand <= '0;
      end else if (start) begin
         cnt    <= '0;
         div_q  <= div_op;
         neg_q  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         divz_q <= div_op && (b == '0);
         a_raw  <= a;
         prod   <= '0;
         mcand  <= {{WIDTH{1'b0}}, a_mag};
         mplr   <= b_mag;
         rem    <= '0;
         quot   <= a_mag;
         dvsr   <= b_mag;
      end else if (step) begin
         cnt <= cnt + 1'b1;
         if (div_q) begin
            rem  <= r_ge ? WIDTH'(r_sh - {1'b0, dvsr}) : r_sh[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], r_ge};
         end else begin
            if (mplr[0])
               prod <= prod + mcand;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
         end
      end
   end

`ifdef MDU_EARLY_TERM_EN
   assign done = step && ((cnt == CNT_W'(WIDTH - 1)) || (!div_q && (mplr[WIDTH-1:1] == '0)));
`else
   assign done = step && (cnt == CNT_W'(WIDTH - 1));
`endif

   assign prod_s = neg_q ? -prod : prod;
   assign q_s    = neg_q ? -quot : quot;
   assign r_s    = neg_r ? -rem : rem;

   // Divide by zero bypasses the magnitude path: quotient all ones, remainder is the raw dividend.
   always_comb begin
      hi_res = r_s;
      lo_res = q_s;
      if (divz_q) begin
         hi_res = a_raw;
         lo_res = '1;
      end else if (!div_q) begin
         {hi_res, lo_res} = prod_s;
      end
   end

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode plus iterative MDU with HI/LO; WIDTH+1 busy cycles per mult/div (fewer with MDU_EARLY_TERM_EN).
// Any MDU funct arriving while busy raises stall until the cycle after md_done; other ops never stall.
import alu_pkg::*;

module alu_control_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       ALUOp,
   input  logic [5:0]       Funct,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic [4:0]       ALUCtl,
   output logic             Sign,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             md_busy,
   output logic             md_done,
   output logic             stall
);
   md_state_t        state;
   logic             md_op, start, mt_wr, iter_done;
   logic [WIDTH-1:0] res_hi, res_lo;

   always_comb begin
      ALUCtl = CTL_ADD;
      case (ALUOp[2:0])
         OP_SUB: ALUCtl = CTL_SUB;
         OP_AND: ALUCtl = CTL_AND;
         OP_SLT: ALUCtl = CTL_SLT;
         OP_MUL: ALUCtl = CTL_MUL;
         OP_RTYPE: begin
            case (Funct)
               6'b000000:            ALUCtl = CTL_SLL;
               6'b000010:            ALUCtl = CTL_SRL;
               6'b000011:            ALUCtl = CTL_SRA;
               6'b100010, 6'b100011: ALUCtl = CTL_SUB;
               6'b100100:            ALUCtl = CTL_AND;
               6'b100101:            ALUCtl = CTL_OR;
               6'b100110:            ALUCtl = CTL_XOR;
               6'b100111:            ALUCtl = CTL_NOR;
               6'b101010, 6'b101011: ALUCtl = CTL_SLT;
               default:              ALUCtl = CTL_ADD;
            endcase
         end
         default: ALUCtl = CTL_ADD;
      endcase
   end

   assign Sign  = (ALUOp[2:0] == OP_RTYPE) ? ~Funct[0] : ~ALUOp[3];

   assign md_op = in_valid && (ALUOp[2:0] == OP_RTYPE) && is_md_funct(Funct);
   assign stall = md_op && md_busy;
   assign start = md_op && (state == IDLE) && is_muldiv(Funct);
   assign mt_wr = md_op && (state == IDLE) && ((Funct == F_MTHI) || (Funct == F_MTLO));

   mdu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .step   (state == RUN),
      .div_op (Funct[1]),
      .sgn    (~Funct[0]),
      .a      (rs_data),
      .b      (rt_data),
      .done   (iter_done),
      .hi_res (res_hi),
      .lo_res (res_lo)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         hi      <= '0;
         lo      <= '0;
         md_busy <= 1'b0;
         md_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= RUN;
                  md_busy <= 1'b1;
`ifdef MDU_EARLY_TERM_EN
                  if (Funct[1] && (rt_data == '0)) begin
                     state   <= FIN;
                     md_done <= 1'b1;
                  end
`endif
               end else if (mt_wr) begin
                  if (Funct == F_MTHI)
                     hi <= rs_data;
                  else
                     lo <= rs_data;
               end
            end
            RUN: begin
               if (iter_done) begin
                  state   <= FIN;
                  md_done <= 1'b1;
               end
            end
            FIN: begin
               hi      <= res_hi;
               lo      <= res_lo;
               state   <= IDLE;
               md_busy <= 1'b0;
               md_done <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
